// File: rtl/issue_select.sv
// Oldest-first issue selector for a reservation station.
// It tracks entries, orders them with an age matrix and paces grants by the FU initiation interval.
module issue_select #(
  parameter int RS_ENTRIES = 8,
  parameter int ISSUE_II   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            disp_valid,
  input  logic [$clog2(RS_ENTRIES)-1:0]   disp_entry,
  input  logic [RS_ENTRIES-1:0]           reqs,
  input  logic                            fu_ready,
  input  logic                            flush,
  output logic [RS_ENTRIES-1:0]           grant,
  output logic                            grant_valid,
  output logic [$clog2(RS_ENTRIES)-1:0]   grant_idx,
  output logic [$clog2(RS_ENTRIES):0]     pending_cnt
);

  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int CNT_W = $clog2(RS_ENTRIES) + 1;

  function automatic logic [CNT_W-1:0] popcount(input logic [RS_ENTRIES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  logic [RS_ENTRIES-1:0] tracked_r;
  logic [RS_ENTRIES-1:0] tracked_nxt_s;
  logic [RS_ENTRIES-1:0] age_r     [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] age_nxt_s [RS_ENTRIES];
  logic [3:0]            ii_cnt_r;
  logic [3:0]            ii_cnt_nxt_s;

  logic [RS_ENTRIES-1:0] disp_oh_s;
  logic [RS_ENTRIES-1:0] eligible_s;
  logic [RS_ENTRIES-1:0] blocked_s;
  logic [RS_ENTRIES-1:0] select_s;
  logic [IDX_W-1:0]      select_idx_s;
  logic                  grant_fire_s;

  logic [RS_ENTRIES-1:0] grant_r;
  logic                  grant_valid_r;
  logic [IDX_W-1:0]      grant_idx_r;
  logic [CNT_W-1:0]      pending_cnt_r;

  // Decode the dispatched entry into a one-hot mask.
  always_comb begin
    disp_oh_s = '0;
    if (disp_valid) begin
      disp_oh_s[disp_entry] = 1'b1;
    end else begin
      disp_oh_s = '0;
    end
  end

  // Pick the eligible entry that no other eligible entry is older than.
  always_comb begin
    eligible_s = reqs & tracked_r & ~disp_oh_s;
    blocked_s  = '0;
    select_s   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int j = 0; j < RS_ENTRIES; j++) begin
        blocked_s[i] = blocked_s[i] | ((j != i) & eligible_s[j] & age_r[j][i]);
      end
      select_s[i] = eligible_s[i] & ~blocked_s[i];
    end
    grant_fire_s = (|eligible_s) & fu_ready & ~flush & (ii_cnt_r == 4'd0);
  end

  // Encode the one-hot selection into a binary index.
  always_comb begin
    select_idx_s = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      select_idx_s = select_idx_s | (select_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  // Next tracked set, age matrix and initiation-interval counter.
  always_comb begin
    tracked_nxt_s = tracked_r;
    age_nxt_s     = age_r;
    ii_cnt_nxt_s  = ii_cnt_r;
    if (flush) begin
      tracked_nxt_s = '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        age_nxt_s[i] = '0;
      end
      ii_cnt_nxt_s = 4'd0;
    end else begin
      tracked_nxt_s = (tracked_r & ~(grant_fire_s ? select_s : {RS_ENTRIES{1'b0}})) | disp_oh_s;
      if (disp_valid) begin
        // The new entry is younger than everything already tracked, itself included never.
        for (int i = 0; i < RS_ENTRIES; i++) begin
          if (IDX_W'(i) == disp_entry) begin
            age_nxt_s[i] = '0;
          end else begin
            age_nxt_s[i][disp_entry] = tracked_r[i];
          end
        end
      end else begin
        age_nxt_s = age_r;
      end
      if (grant_fire_s) begin
        ii_cnt_nxt_s = 4'(ISSUE_II - 1);
      end else if (ii_cnt_r != 4'd0) begin
        ii_cnt_nxt_s = ii_cnt_r - 4'd1;
      end else begin
        ii_cnt_nxt_s = ii_cnt_r;
      end
    end
  end

  // Tracking state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tracked_r <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        age_r[i] <= '0;
      end
      ii_cnt_r <= 4'd0;
    end else begin
      tracked_r <= tracked_nxt_s;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        age_r[i] <= age_nxt_s[i];
      end
      ii_cnt_r <= ii_cnt_nxt_s;
    end
  end

  // Registered grant and occupancy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      grant_idx_r   <= '0;
      pending_cnt_r <= '0;
    end else begin
      grant_r       <= grant_fire_s ? select_s : {RS_ENTRIES{1'b0}};
      grant_valid_r <= grant_fire_s;
      grant_idx_r   <= grant_fire_s ? select_idx_s : {IDX_W{1'b0}};
      pending_cnt_r <= popcount(tracked_nxt_s);
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign pending_cnt = pending_cnt_r;

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: a vector table for single-cycle behaviour,
// plus sequences for initiation-interval spacing and asynchronous reset.
module tb_issue_select;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_valid, fu_ready, flush;
  logic [2:0] disp_entry;
  logic [7:0] reqs, grant;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [3:0] pending_cnt;

  logic       disp_valid3, fu_ready3, flush3;
  logic [2:0] disp_entry3;
  logic [7:0] reqs3, grant3;
  logic       grant_valid3;
  logic [2:0] grant_idx3;
  logic [3:0] pending_cnt3;

  int checks = 0;
  int failures = 0;

  issue_select #(.RS_ENTRIES(8), .ISSUE_II(1)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_entry(disp_entry),
    .reqs(reqs), .fu_ready(fu_ready), .flush(flush), .grant(grant),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .pending_cnt(pending_cnt)
  );

  issue_select #(.RS_ENTRIES(8), .ISSUE_II(3)) dut3 (
    .clk(clk), .rst(rst), .disp_valid(disp_valid3), .disp_entry(disp_entry3),
    .reqs(reqs3), .fu_ready(fu_ready3), .flush(flush3), .grant(grant3),
    .grant_valid(grant_valid3), .grant_idx(grant_idx3), .pending_cnt(pending_cnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [2:0] de;
    logic [7:0] rq;
    logic       fr;
    logic       fl;
    logic       egv;
    logic [2:0] eidx;
    logic [3:0] ep;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic dv, input logic [2:0] de, input logic [7:0] rq,
                      input logic fr, input logic fl, input logic egv,
                      input logic [2:0] eidx, input logic [3:0] ep);
    vec_t v;
    v.dv = dv; v.de = de; v.rq = rq; v.fr = fr; v.fl = fl;
    v.egv = egv; v.eidx = eidx; v.ep = ep;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_grant;
    logic       exp_gv;
    logic [2:0] exp_idx;
    logic [3:0] exp_pend;

    rst = 1'b1;
    disp_valid = 1'b0; disp_entry = 3'd0; reqs = 8'h00; fu_ready = 1'b0; flush = 1'b0;
    disp_valid3 = 1'b0; disp_entry3 = 3'd0; reqs3 = 8'h00; fu_ready3 = 1'b0; flush3 = 1'b0;
    #2;
    check("reset_gv", {31'd0, grant_valid}, 32'd0);
    check("reset_grant", {24'd0, grant}, 32'd0);
    check("reset_idx", {29'd0, grant_idx}, 32'd0);
    check("reset_pend", {28'd0, pending_cnt}, 32'd0);
    check("reset_gv3", {31'd0, grant_valid3}, 32'd0);
    tick();
    rst = 1'b0;

    // dv de rq fr fl | egv eidx ep
    addv(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    // age order 5, 2, 7
    addv(1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1);
    addv(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    addv(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3);
    addv(1'b0, 3'd0, 8'hA4, 1'b1, 1'b0, 1'b1, 3'd5, 4'd2);
    addv(1'b0, 3'd0, 8'hA4, 1'b1, 1'b0, 1'b1, 3'd2, 4'd1);
    addv(1'b0, 3'd0, 8'hA4, 1'b1, 1'b0, 1'b1, 3'd7, 4'd0);
    addv(1'b0, 3'd0, 8'hA4, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    // back-pressure with 3 older than 1
    addv(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1);
    addv(1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    for (int i = 0; i < 3; i++) addv(1'b0, 3'd0, 8'h0A, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    addv(1'b0, 3'd0, 8'h0A, 1'b1, 1'b0, 1'b1, 3'd3, 4'd1);
    addv(1'b0, 3'd0, 8'h0A, 1'b1, 1'b0, 1'b1, 3'd1, 4'd0);
    addv(1'b0, 3'd0, 8'h0A, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    // dispatch of entry 4 in the cycle entry 0 is granted
    addv(1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1);
    addv(1'b1, 3'd4, 8'h11, 1'b1, 1'b0, 1'b1, 3'd0, 4'd1);
    addv(1'b0, 3'd0, 8'h10, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0);
    addv(1'b0, 3'd0, 8'h10, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    // re-dispatch of a tracked entry makes it youngest
    addv(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1);
    addv(1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    addv(1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    addv(1'b0, 3'd0, 8'h42, 1'b1, 1'b0, 1'b1, 3'd1, 4'd1);
    addv(1'b0, 3'd0, 8'h42, 1'b1, 1'b0, 1'b1, 3'd6, 4'd0);
    // flush with six tracked entries; dispatch in the flush cycle is dropped
    for (int i = 0; i < 6; i++) addv(1'b1, 3'(i), 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'(i + 1));
    addv(1'b1, 3'd6, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
    addv(1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    addv(1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    addv(1'b1, 3'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 4'd1);
    addv(1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd2, 4'd0);
    // fill every entry, then re-dispatch one and flush
    for (int i = 0; i < 8; i++) addv(1'b1, 3'(i), 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'(i + 1));
    addv(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8);
    addv(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);

    for (int n = 0; n < vq.size(); n++) begin
      disp_valid = vq[n].dv; disp_entry = vq[n].de; reqs = vq[n].rq;
      fu_ready = vq[n].fr; flush = vq[n].fl;
      tick();
      exp_grant = vq[n].egv ? (8'd1 << vq[n].eidx) : 8'd0;
      check($sformatf("v%0d_gv", n), {31'd0, grant_valid}, {31'd0, vq[n].egv});
      check($sformatf("v%0d_grant", n), {24'd0, grant}, {24'd0, exp_grant});
      check($sformatf("v%0d_idx", n), {29'd0, grant_idx}, {29'd0, vq[n].eidx});
      check($sformatf("v%0d_pend", n), {28'd0, pending_cnt}, {28'd0, vq[n].ep});
    end
    disp_valid = 1'b0; reqs = 8'h00; fu_ready = 1'b0; flush = 1'b0;

    // Initiation interval of 3 with four requesting entries
    for (int i = 0; i < 4; i++) begin
      disp_valid3 = 1'b1; disp_entry3 = 3'(i);
      tick();
    end
    check("ii_fill_pend", {28'd0, pending_cnt3}, 32'd4);
    disp_valid3 = 1'b0; reqs3 = 8'h0F; fu_ready3 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      exp_gv   = ((k % 3) == 0) && (k <= 9);
      exp_idx  = exp_gv ? 3'(k / 3) : 3'd0;
      exp_pend = (k >= 9) ? 4'd0 : 4'(3 - (k / 3));
      check($sformatf("ii_k%0d_gv", k), {31'd0, grant_valid3}, {31'd0, exp_gv});
      check($sformatf("ii_k%0d_idx", k), {29'd0, grant_idx3}, {29'd0, exp_idx});
      check($sformatf("ii_k%0d_pend", k), {28'd0, pending_cnt3}, {28'd0, exp_pend});
    end
    reqs3 = 8'h00; fu_ready3 = 1'b0;

    // Asynchronous reset while a grant is showing and another is in flight
    disp_valid = 1'b1; disp_entry = 3'd4;
    tick();
    disp_valid = 1'b1; disp_entry = 3'd2; reqs = 8'h14; fu_ready = 1'b1;
    tick();
    check("ar_pre_gv", {31'd0, grant_valid}, 32'd1);
    check("ar_pre_idx", {29'd0, grant_idx}, 32'd4);
    check("ar_pre_pend", {28'd0, pending_cnt}, 32'd1);
    disp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_gv", {31'd0, grant_valid}, 32'd0);
    check("ar_grant", {24'd0, grant}, 32'd0);
    check("ar_idx", {29'd0, grant_idx}, 32'd0);
    check("ar_pend", {28'd0, pending_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("ar_post%0d_gv", k), {31'd0, grant_valid}, 32'd0);
      check($sformatf("ar_post%0d_pend", k), {28'd0, pending_cnt}, 32'd0);
    end
    disp_valid = 1'b1; disp_entry = 3'd2;
    tick();
    disp_valid = 1'b0;
    tick();
    check("ar_redisp_gv", {31'd0, grant_valid}, 32'd1);
    check("ar_redisp_idx", {29'd0, grant_idx}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Parameter RS_ENTRIES SHALL default to 8; it is the number of reservation-station entries and matches the wakeup block.
REQ-003 Parameter ISSUE_II SHALL default to 1; it is the minimum number of cycles between grants (functional-unit initiation interval, 1..15).
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port disp_valid  input  1  an entry is allocated this cycle.
REQ-007 Port disp_entry  input  $clog2(RS_ENTRIES)  index of the allocated entry.
REQ-008 Port reqs  input  RS_ENTRIES  per-entry ready-to-issue request from wakeup.
REQ-009 Port fu_ready  input  1  the functional unit can accept an op this cycle.
REQ-010 Port flush  input  1  synchronous squash of all tracked entries.
REQ-011 Port grant  output  RS_ENTRIES  registered one-hot grant to wakeup; all zero when grant_valid=0.
REQ-012 Port grant_valid  output  1  registered; grant is meaningful.
REQ-013 Port grant_idx  output  $clog2(RS_ENTRIES)  registered binary index of grant; 0 when grant_valid=0.
REQ-014 Port pending_cnt  output  $clog2(RS_ENTRIES)+1  registered count of tracked, un-issued entries.

Function
REQ-015 The block SHALL keep a per-entry tracked bit and an RS_ENTRIES x RS_ENTRIES age matrix; age[i][j]=1 means entry i is older than entry j.
REQ-016 On disp_valid, entry disp_entry SHALL become tracked and youngest: age[disp_entry][*] cleared, age[*][disp_entry] set for every other tracked entry.
REQ-017 Eligible set = reqs AND tracked, excluding any entry dispatched in the same cycle.
REQ-018 Selection SHALL pick the eligible entry with no older eligible entry (oldest-first); ties cannot occur.
REQ-019 A grant SHALL be issued when the eligible set is non-empty, fu_ready=1, flush=0 and the II counter is 0.
REQ-020 Latency: reqs sampled in cycle N -> grant/grant_valid/grant_idx visible in cycle N+1, held for exactly one cycle.
REQ-021 At the edge that registers a grant, the granted entry's tracked bit SHALL clear; it cannot be granted again until re-dispatched.
REQ-022 On each grant, the II counter SHALL load ISSUE_II-1 and decrement by 1 per cycle to 0; with ISSUE_II=1 back-to-back grants are allowed.
REQ-023 fu_ready=0 SHALL suppress the grant without modifying the tracked bits, the age matrix or the II counter (apart from its normal decrement).
REQ-024 Dispatch to an already-tracked entry SHALL re-age it as youngest; pending_cnt is unchanged.
REQ-025 A dispatch and a grant in the same cycle SHALL both take effect; pending_cnt change = +1 - 1 = 0, saturating at RS_ENTRIES.
REQ-026 flush=1 SHALL, at the next edge, clear all tracked bits, the age matrix, the II counter, grant_valid and pending_cnt; a disp_valid in the flush cycle SHALL be ignored.
REQ-027 pending_cnt SHALL equal popcount(tracked) after each edge.

Reset
REQ-028 While rst=1, regardless of clk: grant=0, grant_valid=0, grant_idx=0, pending_cnt=0, all tracked bits 0, age matrix 0, II counter 0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight grant; the first grant after deassertion requires a fresh dispatch.

Verification
REQ-030 Age order: dispatch entries 5, 2, 7 on consecutive cycles, then reqs=8'hA4 with fu_ready=1 -> grant_idx sequence 5, 2, 7 on three consecutive cycles, then grant_valid=0.
REQ-031 Back-pressure: entries 3 and 1 tracked (3 older), reqs=8'h0A, fu_ready=0 for 3 cycles -> no grant and pending_cnt=2; fu_ready=1 -> grant=8'h08, then 8'h02.
REQ-032 II spacing: ISSUE_II=3, four tracked requesting entries -> grant_valid high on cycles N, N+3, N+6, N+9 only.
REQ-033 Same-cycle dispatch/grant: entry 0 requesting, dispatch entry 4 in the grant cycle -> grant_idx=0, pending_cnt unchanged, entry 4 not granted that cycle.
REQ-034 Flush: 6 tracked entries with reqs=8'hFF, flush=1 for one cycle -> next cycle pending_cnt=0 and grant_valid=0, and no further grants until a new dispatch.
REQ-035 Async reset: assert rst between clock edges while grant_valid=1 -> grant_valid and grant drop to 0 immediately without a clock edge.
